// File: rtl/vga_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_writer
// Purpose  : Gathers single-pixel writes for a 256x192 8bpp framebuffer into
//            byte-masked 32-bit words, one memory write + command per word.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_writer #(
    parameter logic [29:0] FB_BASE_ADDR = 30'h0000000,
    parameter int          FLUSH_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        calib_done,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic [7:0]  px_x,
    input  logic [7:0]  px_y,
    input  logic [7:0]  px_color,
    input  logic        flush,
    output logic        idle,
    output logic        wr_error,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    input  logic        mem_cmd_full,
    output logic        mem_wr_en,
    output logic [3:0]  mem_wr_mask,
    output logic [31:0] mem_wr_data,
    input  logic        mem_wr_full,
    input  logic        mem_wr_underrun,
    input  logic        mem_wr_error
);

    localparam int c_CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FLUSH_CYCLES - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_GATHER  = 2'd1;
    localparam logic [1:0] c_WR_DATA = 2'd2;
    localparam logic [1:0] c_WR_CMD  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [29:0]        r_addr;
    logic [31:0]        r_data;
    logic [3:0]         r_mask;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_hold_valid;
    logic [29:0]        r_hold_addr;
    logic [1:0]         r_hold_lane;
    logic [7:0]         r_hold_color;
    logic               r_wr_error;

    logic [29:0]        w_px_word_addr;
    logic [1:0]         w_px_lane;
    logic               w_accept;
    logic               w_same_word;
    logic               w_load_px;
    logic               w_merge_px;
    logic               w_capture_hold;
    logic               w_load_hold;
    logic               w_cnt_inc;

    // Base is word aligned, so the lane is px_x[1:0] and only the word part needs an adder.
    assign w_px_word_addr = {FB_BASE_ADDR[29:2] + {14'd0, px_y, px_x[7:2]}, 2'b00};
    assign w_px_lane      = px_x[1:0];
    assign w_same_word    = (w_px_word_addr == r_addr);
    assign w_accept       = px_valid && px_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_load_px      = 1'b0;
        w_merge_px     = 1'b0;
        w_capture_hold = 1'b0;
        w_load_hold    = 1'b0;
        w_cnt_inc      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_load_px    = 1'b1;
                    w_next_state = c_GATHER;
                end
            end
            c_GATHER: begin
                if (w_accept && !w_same_word) begin
                    w_capture_hold = 1'b1;
                    w_next_state   = c_WR_DATA;
                end else if (w_accept) begin
                    w_merge_px = 1'b1;
                    if (flush || (r_mask == 4'b0000)) begin
                        w_next_state = c_WR_DATA;
                    end
                end else if (flush || (r_mask == 4'b0000) || (r_cnt == c_CNT_LAST)) begin
                    w_next_state = c_WR_DATA;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            c_WR_DATA: begin
                if (!mem_wr_full) begin
                    w_next_state = c_WR_CMD;
                end
            end
            c_WR_CMD: begin
                if (!mem_cmd_full) begin
                    if (r_hold_valid) begin
                        w_load_hold  = 1'b1;
                        w_next_state = c_GATHER;
                    end else begin
                        w_next_state = c_IDLE;
                    end
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // rst_n gates px_ready so nothing is accepted while reset is held.
    always_comb begin
        px_ready   = 1'b0;
        idle       = 1'b0;
        mem_wr_en  = 1'b0;
        mem_cmd_en = 1'b0;
        case (r_state)
            c_IDLE: begin
                px_ready = calib_done && rst_n;
                idle     = 1'b1;
            end
            c_GATHER:  px_ready   = calib_done && rst_n;
            c_WR_DATA: mem_wr_en  = !mem_wr_full;
            c_WR_CMD:  mem_cmd_en = !mem_cmd_full;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= FB_BASE_ADDR;
            r_data       <= 32'd0;
            r_mask       <= 4'hF;
            r_cnt        <= '0;
            r_hold_valid <= 1'b0;
            r_hold_addr  <= 30'd0;
            r_hold_lane  <= 2'd0;
            r_hold_color <= 8'd0;
        end else begin
            if (w_load_px) begin
                r_addr <= w_px_word_addr;
                r_data <= {24'd0, px_color} << {w_px_lane, 3'b000};
                r_mask <= ~(4'b0001 << w_px_lane);
            end else if (w_merge_px) begin
                r_data[{w_px_lane, 3'b000} +: 8] <= px_color;
                r_mask[w_px_lane]                <= 1'b0;
            end else if (w_load_hold) begin
                r_addr <= r_hold_addr;
                r_data <= {24'd0, r_hold_color} << {r_hold_lane, 3'b000};
                r_mask <= ~(4'b0001 << r_hold_lane);
            end

            if (w_capture_hold) begin
                r_hold_valid <= 1'b1;
                r_hold_addr  <= w_px_word_addr;
                r_hold_lane  <= w_px_lane;
                r_hold_color <= px_color;
            end else if (w_load_hold) begin
                r_hold_valid <= 1'b0;
            end

            if (w_load_px || w_merge_px || w_load_hold) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_error <= 1'b0;
        end else if (mem_wr_underrun || mem_wr_error) begin
            r_wr_error <= 1'b1;
        end
    end

    assign wr_error          = r_wr_error;
    assign mem_cmd_instr     = 3'b000;
    assign mem_cmd_bl        = 6'd0;
    assign mem_cmd_byte_addr = r_addr;
    assign mem_wr_mask       = r_mask;
    assign mem_wr_data       = r_data;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_writer
// Purpose  : Directed self-checking bench for vga_fb_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        calib_done = 1'b0;
    logic        px_valid = 1'b0;
    logic        px_ready;
    logic [7:0]  px_x = 8'd0;
    logic [7:0]  px_y = 8'd0;
    logic [7:0]  px_color = 8'd0;
    logic        flush = 1'b0;
    logic        idle;
    logic        wr_error;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        mem_cmd_full = 1'b0;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_wr_data;
    logic        mem_wr_full = 1'b0;
    logic        mem_wr_underrun = 1'b0;
    logic        mem_wr_error = 1'b0;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int wr_cnt  = 0;
    int cmd_cnt = 0;
    int wr_cyc  = 0;
    int cmd_cyc = 0;
    int acc_cyc = 0;
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_mask_q[$];
    logic [29:0] cmd_addr_q[$];
    logic [7:0]  fw_cols [4] = '{8'd11, 8'd22, 8'd33, 8'd44};

    vga_fb_writer #(
        .FB_BASE_ADDR (30'h0000000),
        .FLUSH_CYCLES (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .calib_done        (calib_done),
        .px_valid          (px_valid),
        .px_ready          (px_ready),
        .px_x              (px_x),
        .px_y              (px_y),
        .px_color          (px_color),
        .flush             (flush),
        .idle              (idle),
        .wr_error          (wr_error),
        .mem_cmd_en        (mem_cmd_en),
        .mem_cmd_instr     (mem_cmd_instr),
        .mem_cmd_bl        (mem_cmd_bl),
        .mem_cmd_byte_addr (mem_cmd_byte_addr),
        .mem_cmd_full      (mem_cmd_full),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_mask       (mem_wr_mask),
        .mem_wr_data       (mem_wr_data),
        .mem_wr_full       (mem_wr_full),
        .mem_wr_underrun   (mem_wr_underrun),
        .mem_wr_error      (mem_wr_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every push on the memory port and the cycle of each accepted pixel.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_cnt++;
            wr_cyc = cyc;
            wr_data_q.push_back(mem_wr_data);
            wr_mask_q.push_back(mem_wr_mask);
        end
        if (mem_cmd_en) begin
            cmd_cnt++;
            cmd_cyc = cyc;
            cmd_addr_q.push_back(mem_cmd_byte_addr);
        end
        if (px_valid && px_ready) acc_cyc = cyc;
    end

    // Called just after a rising edge; returns just after the edge that accepted the pixel.
    task automatic push_px(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c,
                           output bit ok);
        ok = 1'b0;
        px_x = x; px_y = y; px_color = c; px_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (px_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        px_valid = 1'b0;
    endtask

    task automatic wait_cmds(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (cmd_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; calib_done = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (px_ready !== 1'b0) $display("FAIL rst_px_ready: got %b want 0", px_ready); else n_pass++;
        n_total++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", idle); else n_pass++;
        n_total++; if ({mem_wr_en, mem_cmd_en} !== 2'b00) $display("FAIL rst_pulses: got %b want 00", {mem_wr_en, mem_cmd_en}); else n_pass++;
        n_total++; if (wr_error !== 1'b0) $display("FAIL rst_wr_error: got %b want 0", wr_error); else n_pass++;
        n_total++; if (mem_wr_mask !== 4'hF) $display("FAIL rst_mask: got %h want f", mem_wr_mask); else n_pass++;
        n_total++; if (mem_wr_data !== 32'h0) $display("FAIL rst_data: got %h want 0", mem_wr_data); else n_pass++;
        n_total++; if (mem_cmd_byte_addr !== 30'h0) $display("FAIL rst_addr: got %h want 0", mem_cmd_byte_addr); else n_pass++;
        n_total++; if ({mem_cmd_instr, mem_cmd_bl} !== 9'd0) $display("FAIL rst_cmd_const: got %h want 0", {mem_cmd_instr, mem_cmd_bl}); else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (px_ready !== 1'b1) $display("FAIL post_rst_ready: got %b want 1", px_ready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_calib;
        calib_done = 1'b0;
        @(negedge clk);
        n_total++; if (px_ready !== 1'b0) $display("FAIL calib_ready: got %b want 0", px_ready); else n_pass++;
        @(posedge clk); #1; calib_done = 1'b1;
    endtask

    task automatic test_full_word;
        int w0, c0;
        bit ok;
        w0 = wr_cnt; c0 = cmd_cnt;
        for (int i = 0; i < 4; i++) begin
            push_px(8'(8 + i), 8'd1, fw_cols[i], ok);
            n_total++; if (!ok) $display("FAIL fw_accept%0d: got timeout want accept", i); else n_pass++;
        end
        wait_cmds(c0 + 1, 40, ok);
        n_total++; if (!ok) $display("FAIL fw_cmd_wait: got timeout want command"); else n_pass++;
        n_total++; if (wr_cnt - w0 !== 1) $display("FAIL fw_wr_count: got %0d want 1", wr_cnt - w0); else n_pass++;
        n_total++; if ((wr_cnt > w0 ? wr_data_q[w0] : 32'hx) !== 32'h2C21160B) $display("FAIL fw_data: got %h want 2c21160b", wr_cnt > w0 ? wr_data_q[w0] : 32'hx); else n_pass++;
        n_total++; if ((wr_cnt > w0 ? wr_mask_q[w0] : 4'hx) !== 4'h0) $display("FAIL fw_mask: got %h want 0", wr_cnt > w0 ? wr_mask_q[w0] : 4'hx); else n_pass++;
        n_total++; if ((cmd_cnt > c0 ? cmd_addr_q[c0] : 30'hx) !== 30'h108) $display("FAIL fw_addr: got %h want 108", cmd_cnt > c0 ? cmd_addr_q[c0] : 30'hx); else n_pass++;
        n_total++; if (wr_cyc - acc_cyc !== 2) $display("FAIL fw_wr_latency: got %0d want 2", wr_cyc - acc_cyc); else n_pass++;
        n_total++; if (cmd_cyc - acc_cyc !== 3) $display("FAIL fw_cmd_latency: got %0d want 3", cmd_cyc - acc_cyc); else n_pass++;
        @(negedge clk);
        n_total++; if (idle !== 1'b1) $display("FAIL fw_idle: got %b want 1", idle); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        int w0, c0;
        bit ok;
        w0 = wr_cnt; c0 = cmd_cnt;
        push_px(8'd5, 8'd0, 8'hE0, ok);
        n_total++; if (!ok) $display("FAIL to_accept: got timeout want accept"); else n_pass++;
        wait_cmds(c0 + 1, 40, ok);
        n_total++; if (!ok) $display("FAIL to_cmd_wait: got timeout want command"); else n_pass++;
        n_total++; if ((wr_cnt > w0 ? wr_data_q[w0][15:8] : 8'hx) !== 8'hE0) $display("FAIL to_lane1: got %h want e0", wr_cnt > w0 ? wr_data_q[w0][15:8] : 8'hx); else n_pass++;
        n_total++; if ((wr_cnt > w0 ? wr_mask_q[w0] : 4'hx) !== 4'hD) $display("FAIL to_mask: got %h want d", wr_cnt > w0 ? wr_mask_q[w0] : 4'hx); else n_pass++;
        n_total++; if ((cmd_cnt > c0 ? cmd_addr_q[c0] : 30'hx) !== 30'h4) $display("FAIL to_addr: got %h want 4", cmd_cnt > c0 ? cmd_addr_q[c0] : 30'hx); else n_pass++;
        n_total++; if (wr_cyc - acc_cyc !== 17) $display("FAIL to_wr_latency: got %0d want 17", wr_cyc - acc_cyc); else n_pass++;
        n_total++; if (cmd_cyc - acc_cyc !== 18) $display("FAIL to_cmd_latency: got %0d want 18", cmd_cyc - acc_cyc); else n_pass++;
        @(negedge clk);
        n_total++; if (idle !== 1'b1) $display("FAIL to_idle: got %b want 1", idle); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int w0, c0;
        bit ok0, ok1, ok;
        w0 = wr_cnt; c0 = cmd_cnt;
        push_px(8'd0, 8'd0, 8'h5A, ok0);
        push_px(8'd4, 8'd0, 8'hA5, ok1);
        n_total++; if (!(ok0 && ok1)) $display("FAIL b2b_accept: got %b%b want 11", ok0, ok1); else n_pass++;
        wait_cmds(c0 + 2, 60, ok);
        n_total++; if (!ok) $display("FAIL b2b_cmd_wait: got %0d cmds want 2", cmd_cnt - c0); else n_pass++;
        n_total++; if ((cmd_cnt > c0 + 1 ? {cmd_addr_q[c0], cmd_addr_q[c0 + 1]} : 60'hx) !== {30'h0, 30'h4}) $display("FAIL b2b_addr: got %h want 0 then 4", cmd_cnt > c0 + 1 ? {cmd_addr_q[c0], cmd_addr_q[c0 + 1]} : 60'hx); else n_pass++;
        n_total++; if ((wr_cnt > w0 + 1 ? {wr_mask_q[w0], wr_mask_q[w0 + 1]} : 8'hx) !== 8'hEE) $display("FAIL b2b_mask: got %h want ee", wr_cnt > w0 + 1 ? {wr_mask_q[w0], wr_mask_q[w0 + 1]} : 8'hx); else n_pass++;
        n_total++; if ((wr_cnt > w0 + 1 ? {wr_data_q[w0][7:0], wr_data_q[w0 + 1][7:0]} : 16'hx) !== 16'h5AA5) $display("FAIL b2b_data: got %h want 5aa5", wr_cnt > w0 + 1 ? {wr_data_q[w0][7:0], wr_data_q[w0 + 1][7:0]} : 16'hx); else n_pass++;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int w0, c0;
        bit ok, bad;
        push_px(8'd0, 8'd2, 8'h77, ok);
        n_total++; if (!ok) $display("FAIL bp_accept: got timeout want accept"); else n_pass++;
        mem_wr_full = 1'b1; mem_cmd_full = 1'b1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        w0 = wr_cnt; bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_wr_en || px_ready) bad = 1'b1;
            @(posedge clk); #1;
        end
        n_total++; if (bad || wr_cnt != w0) $display("FAIL bp_wr_stall: got push_or_ready=%b want 0", bad); else n_pass++;
        mem_wr_full = 1'b0;
        @(negedge clk);
        n_total++; if ({mem_wr_en, mem_wr_mask, mem_wr_data[7:0]} !== {1'b1, 4'hE, 8'h77}) $display("FAIL bp_wr_push: got en=%b mask=%h d=%h want 1 e 77", mem_wr_en, mem_wr_mask, mem_wr_data[7:0]); else n_pass++;
        @(posedge clk); #1;
        c0 = cmd_cnt; bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_cmd_en || px_ready) bad = 1'b1;
            @(posedge clk); #1;
        end
        n_total++; if (bad || cmd_cnt != c0) $display("FAIL bp_cmd_stall: got push_or_ready=%b want 0", bad); else n_pass++;
        mem_cmd_full = 1'b0;
        @(negedge clk);
        n_total++; if ({mem_cmd_en, mem_cmd_byte_addr} !== {1'b1, 30'h200}) $display("FAIL bp_cmd_push: got en=%b addr=%h want 1 200", mem_cmd_en, mem_cmd_byte_addr); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++; if (idle !== 1'b1) $display("FAIL bp_idle: got %b want 1", idle); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int w0, c0;
        bit ok;
        push_px(8'd1, 8'd3, 8'h33, ok);
        n_total++; if (!ok) $display("FAIL rm_accept: got timeout want accept"); else n_pass++;
        mem_cmd_full = 1'b1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++; if ({idle, mem_cmd_en, mem_cmd_byte_addr} !== {2'b00, 30'h300}) $display("FAIL rm_stalled: got idle=%b en=%b addr=%h want 0 0 300", idle, mem_cmd_en, mem_cmd_byte_addr); else n_pass++;
        #2; rst_n = 1'b0; #1;
        n_total++; if ({idle, px_ready, mem_cmd_en, mem_wr_en} !== 4'b1000) $display("FAIL rm_async_ctl: got %b want 1000", {idle, px_ready, mem_cmd_en, mem_wr_en}); else n_pass++;
        n_total++; if ({mem_wr_mask, mem_cmd_byte_addr} !== {4'hF, 30'h0}) $display("FAIL rm_async_dp: got mask=%h addr=%h want f 0", mem_wr_mask, mem_cmd_byte_addr); else n_pass++;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1; mem_cmd_full = 1'b0;
        w0 = wr_cnt; c0 = cmd_cnt;
        repeat (20) @(posedge clk); #1;
        n_total++; if ((wr_cnt - w0) + (cmd_cnt - c0) != 0) $display("FAIL rm_no_pulse: got %0d pulses want 0", (wr_cnt - w0) + (cmd_cnt - c0)); else n_pass++;
        @(negedge clk);
        n_total++; if (idle !== 1'b1) $display("FAIL rm_idle: got %b want 1", idle); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_wr_error;
        mem_wr_error = 1'b1;
        @(posedge clk); #1; mem_wr_error = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_total++; if (wr_error !== 1'b1) $display("FAIL err_sticky: got %b want 1", wr_error); else n_pass++;
        rst_n = 1'b0; #1;
        n_total++; if (wr_error !== 1'b0) $display("FAIL err_reset: got %b want 0", wr_error); else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
        mem_wr_underrun = 1'b1;
        @(posedge clk); #1; mem_wr_underrun = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (wr_error !== 1'b1) $display("FAIL err_underrun: got %b want 1", wr_error); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200us want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_calib();
        test_full_word();
        test_timeout();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wr_error();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
